// File: rtl/debug_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_apb_pkg
// Description : Shared definitions for the debug APB arbiter: FSM state
//               encoding, debug window location and size, and the
//               window range/alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [31:0] DEBUG_BASE_ADDR = 32'h4001_0000;
  localparam int          DEBUG_NREG      = 4;

  // Word-aligned and inside [base, base+4*nreg-4]. The compare is carried
  // out in 33 bits so a window near the top of the address map cannot wrap.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int          nreg);
    logic [32:0] w_hi;
    w_hi = {1'b0, base} + 33'(4 * nreg) - 33'd4;
    return (addr[1:0] == 2'b00) &&
           ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} <= w_hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_apb_arb_sel.sv
`default_nettype none
// ============================================================================
// Module      : debug_apb_arb_sel
// Description : Combinational two-way grant selection, one-hot output.
//               Optional feature macro: DEBUG_APB_ARB_RR_EN
//                 defined   -> round robin on ties (grant the one not last)
//                 undefined -> fixed priority, requester 0 wins ties
// Ports       : i_valid0/i_valid1 request pending flags
//               i_last            id of the requester granted last
//               o_grant[1:0]      one-hot grant (bit N = requester N)
// Revision    : 1.0 - initial release
// ============================================================================
module debug_apb_arb_sel (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last,
  output logic [1:0] o_grant
);

`ifdef DEBUG_APB_ARB_RR_EN
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end
`else
  // History is meaningless under fixed priority.
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_grant = 2'b00;
    if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/debug_apb_arb.sv
`default_nettype none
// ============================================================================
// Module      : debug_apb_arb
// Description : Two-requester APB master for the debug register window.
//               Arbitrates single-word requests, runs zero-wait APB
//               setup/access cycles and returns one response pulse to the
//               granted requester. Bad addresses skip the bus and answer
//               with err=1 one cycle after accept.
//               Optional feature macro: DEBUG_APB_ARB_RR_EN (round robin).
// Ports       : clk, rst (async, active high)
//               reqN_valid/ready/write/addr/wdata : request channels N=0,1
//               rspN_valid/err/rdata             : response channels
//               psel/penable/pwrite/paddr/pwdata : APB master outputs
//               prdata                           : APB read data (no pready)
// Revision    : 1.0 - initial release
// ============================================================================
module debug_apb_arb
  import debug_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEBUG_BASE_ADDR,
  parameter int          NREG      = DEBUG_NREG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic        rsp0_err,
  output logic [31:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic        rsp1_err,
  output logic [31:0] rsp1_rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  state_t      r_state;
  logic        r_id;
  logic [1:0]  r_rsp_valid;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;

  logic        w_idle;
  logic        w_last;
  logic [1:0]  w_gnt;
  logic        w_accept;
  logic        w_write;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_ok;

  // rst is folded in so ready drops the instant reset is applied.
  assign w_idle = (r_state == ST_IDLE) && !rst;

  debug_apb_arb_sel u_sel (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_last   (w_last),
    .o_grant  (w_gnt)
  );

  assign req0_ready = w_idle && w_gnt[0];
  assign req1_ready = w_idle && w_gnt[1];
  assign w_accept   = w_idle && (w_gnt != 2'b00);

  assign w_write = w_gnt[1] ? req1_write : req0_write;
  assign w_addr  = w_gnt[1] ? req1_addr  : req0_addr;
  assign w_wdata = w_gnt[1] ? req1_wdata : req0_wdata;
  assign w_ok    = addr_in_window(w_addr, BASE_ADDR, NREG);

`ifdef DEBUG_APB_ARB_RR_EN
  logic r_last;
  // Reset to "requester 1 last" so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt[1];
    end
  end
  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_id        <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id <= w_gnt[1];
            if (w_ok) begin
              // The APB address/data registers double as the request latch.
              r_state  <= ST_SETUP;
              r_psel   <= 1'b1;
              r_pwrite <= w_write;
              r_paddr  <= w_addr;
              r_pwdata <= w_wdata;
            end else begin
              r_state     <= ST_DONE;
              r_rsp_valid <= w_gnt;
              r_err       <= 1'b1;
              r_rdata     <= '0;
            end
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        ST_ACCESS: begin
          r_state     <= ST_DONE;
          r_rdata     <= r_pwrite ? 32'd0 : prdata;
          r_err       <= 1'b0;
          r_rsp_valid <= r_id ? 2'b10 : 2'b01;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_pwrite    <= 1'b0;
          r_paddr     <= '0;
          r_pwdata    <= '0;
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 2'b00;
          r_err       <= 1'b0;
          r_rdata     <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_err   = r_rsp_valid[0] && r_err;
  assign rsp1_err   = r_rsp_valid[1] && r_err;
  assign rsp0_rdata = r_rsp_valid[0] ? r_rdata : 32'd0;
  assign rsp1_rdata = r_rsp_valid[1] ? r_rdata : 32'd0;

  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_debug_apb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_apb_arb
// Description : Directed self-checking bench for debug_apb_arb with a small
//               four-register APB slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_apb_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;

  int n_tests;
  int n_fail;

  debug_apb_arb u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_err   (rsp0_err),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_err   (rsp1_err),
    .rsp1_rdata (rsp1_rdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: four registers, combinational read, write on access edge.
  logic        slv_init;
  logic [31:0] slv [4];
  always @(posedge clk) begin
    if (slv_init) begin
      slv[0] <= 32'h0000_1111;
      slv[1] <= 32'h0000_2222;
      slv[2] <= 32'h1234_5678;
      slv[3] <= 32'h0000_4444;
    end else if (psel && penable && pwrite) begin
      slv[paddr[3:2]] <= pwdata;
    end
  end
  assign prdata = slv[paddr[3:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " psel"},    {31'd0, psel},    32'd0);
    check({tag, " penable"}, {31'd0, penable}, 32'd0);
    check({tag, " paddr"},   paddr,            32'd0);
    check({tag, " pwdata"},  pwdata,           32'd0);
    check({tag, " rsp"},     {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  // One complete request on channel id. Entered and left just after an edge.
  task automatic txn(input int id, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic exp_err,
                     input logic [31:0] exp_rd, input int exp_lat, input string tag);
    int          wait_n, lat, nsel, nen;
    logic        rdy, got, other, gerr;
    logic [31:0] grd, seen_wd;
    if (id == 0) begin
      req0_write = wr; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
    end
    wait_n = 0;
    #1;
    rdy = (id == 0) ? req0_ready : req1_ready;
    while (!rdy && wait_n < 20) begin
      step(); #1;
      wait_n++;
      rdy = (id == 0) ? req0_ready : req1_ready;
    end
    check({tag, " ready"}, {31'd0, rdy}, 32'd1);
    step();
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    lat = 0; nsel = 0; nen = 0; got = 1'b0; other = 1'b0;
    gerr = 1'b0; grd = '0; seen_wd = '0;
    while (!got && lat < 10) begin
      lat++;
      if (psel) begin
        nsel++;
        seen_wd = pwdata;
      end
      if (penable) nen++;
      if ((id == 0) ? rsp1_valid : rsp0_valid) other = 1'b1;
      got  = (id == 0) ? rsp0_valid : rsp1_valid;
      gerr = (id == 0) ? rsp0_err   : rsp1_err;
      grd  = (id == 0) ? rsp0_rdata : rsp1_rdata;
      if (!got) step();
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"},     {31'd0, gerr}, {31'd0, exp_err});
    check({tag, " rdata"},   grd, exp_rd);
    check({tag, " psel cycles"},    nsel, exp_err ? 0 : 2);
    check({tag, " penable cycles"}, nen,  exp_err ? 0 : 1);
    check({tag, " other rsp"}, {31'd0, other}, 32'd0);
    if (wr && !exp_err) check({tag, " pwdata"}, seen_wd, wd);
    step();
    check({tag, " rsp one cycle"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int          order [4];
    int          ng, cyc;
    logic        both;
    n_tests = 0; n_fail = 0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    slv_init = 1'b1;
    rst = 1'b1;
    step(); step();
    slv_init = 1'b0;
    rst = 1'b0;
    step();
    check_idle_outputs("reset");
    check("reset ready", {30'd0, req1_ready, req0_ready}, 32'd0);

    // Write via req0.
    txn(0, 1'b1, 32'h4001_0004, 32'hDEAD_BEEF, 1'b0, 32'd0, 3, "wr0");

    // req1 held with changing payload while req0 owns the bus.
    req0_write = 1'b1; req0_addr = 32'h4001_000C; req0_wdata = 32'hA5A5_A5A5;
    req0_valid = 1'b1;
    #1;
    check("starve r0 ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1; req1_write = k[0];
      req1_addr  = 32'h4001_0000 + 32'(k * 8); req1_wdata = 32'(k);
      #1;
      check($sformatf("starve r1 ready %0d", k), {31'd0, req1_ready}, 32'd0);
      if (k == 2) check("starve r0 rsp", {31'd0, rsp0_valid}, 32'd1);
      step();
    end
    // Read back the earlier write through req1.
    txn(1, 1'b0, 32'h4001_0004, 32'd0, 1'b0, 32'hDEAD_BEEF, 3, "rd1");

    // Bad addresses.
    txn(0, 1'b0, 32'h4001_0010, 32'd0, 1'b0 | 1'b1, 32'd0, 1, "oor");
    txn(0, 1'b0, 32'h4001_0002, 32'd0, 1'b1, 32'd0, 1, "unal");
    txn(1, 1'b1, 32'h4000_FFFC, 32'h77, 1'b1, 32'd0, 1, "below");

    // Earlier write to offset 0xC landed.
    txn(0, 1'b0, 32'h4001_000C, 32'd0, 1'b0, 32'hA5A5_A5A5, 3, "rdC");

    // Reset during ACCESS of a write to offset 0x8.
    req0_write = 1'b1; req0_addr = 32'h4001_0008; req0_wdata = 32'hCAFE_F00D;
    req0_valid = 1'b1;
    step();            // accept edge -> SETUP
    req0_valid = 1'b0;
    step();            // -> ACCESS
    check("pre-rst penable", {31'd0, penable}, 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst async");
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rst no rsp %0d", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    txn(0, 1'b0, 32'h4001_0008, 32'd0, 1'b0, 32'h1234_5678, 3, "rd8");

    // Tie: both valid every cycle for four grants, from a fresh reset.
    do_reset();
    req0_write = 1'b0; req0_addr = 32'h4001_0000; req0_valid = 1'b1;
    req1_write = 1'b0; req1_addr = 32'h4001_000C; req1_valid = 1'b1;
    ng = 0; cyc = 0; both = 1'b0;
    while (ng < 4 && cyc < 40) begin
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready) begin order[ng] = 0; ng++; end
      else if (req1_ready) begin order[ng] = 1; ng++; end
      step();
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("tie grants", ng, 4);
    check("tie one-hot", {31'd0, both}, 32'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef DEBUG_APB_ARB_RR_EN
      check($sformatf("tie order %0d", i), order[i], i % 2);
`else
      check($sformatf("tie order %0d", i), order[i], 0);
`endif
    end
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
